conv_frame_sequencer: RTL and testbench

//   Frame-level controller for the 3x3 convolution datapath. Accepts a stream of
//   3-pixel image columns, loads the 3 kernel columns first, then streams image

---
 rtl/conv_frame_sequencer_if.sv | 21 ++
 rtl/conv_frame_sequencer.sv | 173 +++++++++++++++++
 tb/tb_conv_frame_sequencer.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_frame_sequencer_if.sv
// Column-input and result-output handshake between the sequencer, its column source and the convolver.
// The master modport is the sequencer side; the slave modport is the source/sink side.
interface conv_frame_sequencer_if;
    logic i_col_valid;
    logic o_col_ready;
    logic o_conv_valid;
    logic o_conv_selK_I;
    logic o_res_valid;
    logic o_res_last;
    logic i_res_ready;

    modport master (
        input  i_col_valid, i_res_ready,
        output o_col_ready, o_conv_valid, o_conv_selK_I, o_res_valid, o_res_last
    );

    modport slave (
        output i_col_valid, i_res_ready,
        input  o_col_ready, o_conv_valid, o_conv_selK_I, o_res_valid, o_res_last
    );
endinterface

// File: rtl/conv_frame_sequencer.sv
// 3x3 conv frame sequencer: kernel load, then per-band column stream + flush; result strobe 1 cycle after push.
// `define CONV_SEQ_OUT_BP_EN holds o_res_valid until i_res_ready and stalls pushes meanwhile; else no output stall.
module conv_frame_sequencer #(
    parameter int CNT_W   = 11,
    parameter int MAX_DIM = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic [CNT_W-1:0]     i_width,
    input  logic [CNT_W-1:0]     i_height,
    conv_frame_sequencer_if.master bus,
    output logic [CNT_W-1:0]     o_row,
    output logic [CNT_W-1:0]     o_col,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_KLOAD  = 3'd1,
        S_STREAM = 3'd2,
        S_FLUSH  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_w;
    logic [CNT_W-1:0] r_h;
    logic [CNT_W-1:0] r_row;
    logic [CNT_W-1:0] r_col;
    logic [1:0]       r_kcnt;
    logic             r_res_valid;
    logic             r_res_last;
    logic             r_err;

    logic w_dims_ok;
    logic w_col_ready;
    logic w_selk_i;
    logic w_flush;
    logic w_push;
    logic w_hold;
    logic w_last_band;
    logic w_res_latch;

    assign w_dims_ok = (i_width  >= CNT_W'(3)) && (i_width  <= CNT_W'(MAX_DIM)) &&
                       (i_height >= CNT_W'(3)) && (i_height <= CNT_W'(MAX_DIM));

`ifdef CONV_SEQ_OUT_BP_EN
    assign w_hold = r_res_valid;
`else
    logic w_unused_res_ready;
    assign w_hold             = 1'b0;
    assign w_unused_res_ready = bus.i_res_ready;
`endif

    assign w_last_band = (r_row == r_h - CNT_W'(3));

    always_comb begin
        w_state_nxt = r_state;
        w_col_ready = 1'b0;
        w_selk_i    = 1'b0;
        w_flush     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start && w_dims_ok)
                    w_state_nxt = S_KLOAD;
            end
            S_KLOAD: begin
                w_col_ready = 1'b1;
                if (bus.i_col_valid && r_kcnt == 2'd2)
                    w_state_nxt = S_STREAM;
            end
            S_STREAM: begin
                w_selk_i    = 1'b1;
                w_col_ready = !w_hold;
                if (bus.i_col_valid && !w_hold && r_col == r_w - CNT_W'(1))
                    w_state_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                w_selk_i = 1'b1;
                w_flush  = !w_hold;
                if (!w_hold)
                    w_state_nxt = w_last_band ? S_DONE : S_STREAM;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_push = (bus.i_col_valid && w_col_ready) || w_flush;

    // Band push index p = col+1; the datapath has a full 3x3 window from p = 4 onward.
    assign w_res_latch = w_push &&
                         ((r_state == S_STREAM && r_col >= CNT_W'(3)) || r_state == S_FLUSH);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_w         <= '0;
            r_h         <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_kcnt      <= '0;
            r_res_valid <= 1'b0;
            r_res_last  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= (r_state == S_IDLE) && i_start && !w_dims_ok;

            case (r_state)
                S_IDLE: begin
                    if (i_start && w_dims_ok) begin
                        r_w    <= i_width;
                        r_h    <= i_height;
                        r_row  <= '0;
                        r_col  <= '0;
                        r_kcnt <= '0;
                    end
                end
                S_KLOAD: begin
                    if (w_push)
                        r_kcnt <= r_kcnt + 2'd1;
                end
                S_STREAM: begin
                    if (w_push)
                        r_col <= r_col + CNT_W'(1);
                end
                S_FLUSH: begin
                    if (w_push && !w_last_band) begin
                        r_row <= r_row + CNT_W'(1);
                        r_col <= '0;
                    end
                end
                default: begin
                end
            endcase

`ifdef CONV_SEQ_OUT_BP_EN
            if (w_res_latch) begin
                r_res_valid <= 1'b1;
                r_res_last  <= (r_state == S_FLUSH) && w_last_band;
            end else if (bus.i_res_ready) begin
                r_res_valid <= 1'b0;
                r_res_last  <= 1'b0;
            end
`else
            r_res_valid <= w_res_latch;
            r_res_last  <= w_res_latch && (r_state == S_FLUSH) && w_last_band;
`endif
        end
    end

    assign bus.o_col_ready   = w_col_ready;
    assign bus.o_conv_valid  = w_push;
    assign bus.o_conv_selK_I = w_selk_i;
    assign bus.o_res_valid   = r_res_valid;
    assign bus.o_res_last    = r_res_last;

    assign o_row  = r_row;
    assign o_col  = r_col;
    assign o_busy = (r_state != S_IDLE);
    assign o_done = (r_state == S_DONE);
    assign o_err  = r_err;

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Directed bench for conv_frame_sequencer: frame counts, range errors, input gaps, reset, optional result stall.
module tb_conv_frame_sequencer;
    localparam int CNT_W = 11;

    logic             clk = 1'b0;
    logic             rst;
    logic             i_start;
    logic [CNT_W-1:0] i_width;
    logic [CNT_W-1:0] i_height;
    logic [CNT_W-1:0] o_row;
    logic [CNT_W-1:0] o_col;
    logic             o_busy;
    logic             o_done;
    logic             o_err;

    int n_checks = 0;
    int n_fail   = 0;

    conv_frame_sequencer_if bus ();

    conv_frame_sequencer #(.CNT_W(CNT_W), .MAX_DIM(1024)) dut (
        .clk      (clk),
        .rst      (rst),
        .i_start  (i_start),
        .i_width  (i_width),
        .i_height (i_height),
        .bus      (bus.master),
        .o_row    (o_row),
        .o_col    (o_col),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_err    (o_err)
    );

    always #5 clk = ~clk;

    task automatic test_reset;
        logic [29:0] v;
        rst = 1'b1;
        i_start = 1'b0;
        i_width = '0;
        i_height = '0;
        bus.i_col_valid = 1'b0;
        bus.i_res_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        v = {o_busy, o_done, o_err, bus.o_col_ready, bus.o_conv_valid, bus.o_conv_selK_I,
             bus.o_res_valid, bus.o_res_last, o_row, o_col};
        n_checks++;
        if (v !== 30'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", v);
        end
        rst = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if (o_busy !== 1'b0 || bus.o_col_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b ready=%b expected 0 0", o_busy, bus.o_col_ready);
        end
    endtask

    task automatic run_frame(input string name, input int w, input int h, input bit toggle,
                             input int stall, input int exp_k, input int exp_img,
                             input int exp_res, input int exp_flush);
        int k = 0, img = 0, res = 0, flush = 0, lasts = 0, cyc = 0, stall_left = stall;
        bit done = 1'b0, in_stall = 1'b0, prev_stall = 1'b0, accept;
        @(negedge clk);
        i_start = 1'b1;
        i_width = CNT_W'(w);
        i_height = CNT_W'(h);
        bus.i_col_valid = 1'b1;
        bus.i_res_ready = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        while (!done && cyc < 3000) begin
            if (toggle)
                bus.i_col_valid = (cyc % 2 == 0);
            prev_stall = in_stall;
            in_stall = 1'b0;
`ifdef CONV_SEQ_OUT_BP_EN
            if (bus.o_res_valid && stall_left > 0) begin
                bus.i_res_ready = 1'b0;
                stall_left--;
                in_stall = 1'b1;
            end else begin
                bus.i_res_ready = 1'b1;
            end
`else
            bus.i_res_ready = 1'b0;
`endif
            #1;
            if (in_stall) begin
                n_checks++;
                if (bus.o_col_ready !== 1'b0 || bus.o_conv_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s_stall: ready=%b conv_valid=%b expected 0 0",
                             name, bus.o_col_ready, bus.o_conv_valid);
                end
            end
            if (prev_stall) begin
                n_checks++;
                if (bus.o_res_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s_hold: res_valid=%b expected 1", name, bus.o_res_valid);
                end
            end
            if (bus.o_col_ready === 1'b1) begin
                n_checks++;
                if (bus.o_conv_valid !== bus.i_col_valid) begin
                    n_fail++;
                    $display("FAIL %s_push: conv_valid=%b expected %b at cycle %0d",
                             name, bus.o_conv_valid, bus.i_col_valid, cyc);
                end
            end
            if (bus.o_conv_valid === 1'b1) begin
                if (bus.o_conv_selK_I === 1'b0) k++;
                else img++;
                if (bus.o_col_ready === 1'b0) flush++;
            end
`ifdef CONV_SEQ_OUT_BP_EN
            accept = bus.o_res_valid && bus.i_res_ready;
`else
            accept = bus.o_res_valid;
`endif
            if (accept) begin
                res++;
                if (bus.o_res_last === 1'b1) begin
                    lasts++;
                    n_checks++;
                    if (res != exp_res) begin
                        n_fail++;
                        $display("FAIL %s_last_pos: last on result %0d expected %0d", name, res, exp_res);
                    end
                end
            end
            if (o_done === 1'b1) begin
                done = 1'b1;
                n_checks++;
                if (bus.o_res_last !== 1'b1 || o_busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s_done_cycle: res_last=%b busy=%b expected 1 1",
                             name, bus.o_res_last, o_busy);
                end
            end
            cyc++;
            @(negedge clk);
        end
        #1;
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s_timeout: done=0 after %0d cycles expected 1", name, cyc);
        end
        n_checks++;
        if (k != exp_k || img != exp_img || flush != exp_flush) begin
            n_fail++;
            $display("FAIL %s_pushes: k=%0d img=%0d flush=%0d expected %0d %0d %0d",
                     name, k, img, flush, exp_k, exp_img, exp_flush);
        end
        n_checks++;
        if (res != exp_res || lasts != 1) begin
            n_fail++;
            $display("FAIL %s_results: res=%0d lasts=%0d expected %0d 1", name, res, lasts, exp_res);
        end
        n_checks++;
        if (o_busy !== 1'b0 || o_done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_after_done: busy=%b done=%b expected 0 0", name, o_busy, o_done);
        end
        bus.i_col_valid = 1'b0;
    endtask

    task automatic test_err(input string name, input int w, input int h);
        @(negedge clk);
        i_start = 1'b1;
        i_width = CNT_W'(w);
        i_height = CNT_W'(h);
        bus.i_col_valid = 1'b1;
        @(negedge clk);
        #1;
        n_checks++;
        if (o_err !== 1'b1 || o_busy !== 1'b0 || bus.o_col_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_err: err=%b busy=%b ready=%b expected 1 0 0",
                     name, o_err, o_busy, bus.o_col_ready);
        end
        i_start = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if (o_err !== 1'b0 || o_busy !== 1'b0 || bus.o_conv_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_err_pulse: err=%b busy=%b conv_valid=%b expected 0 0 0",
                     name, o_err, o_busy, bus.o_conv_valid);
        end
        bus.i_col_valid = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic [29:0] v;
        @(negedge clk);
        i_start = 1'b1;
        i_width = CNT_W'(8);
        i_height = CNT_W'(8);
        bus.i_col_valid = 1'b1;
        bus.i_res_ready = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (12) @(negedge clk);
        #1;
        n_checks++;
        if (o_busy !== 1'b1 || o_row !== CNT_W'(1)) begin
            n_fail++;
            $display("FAIL reset_mid_pre: busy=%b row=%0d expected 1 1", o_busy, o_row);
        end
        rst = 1'b1;
        @(negedge clk);
        #1;
        v = {o_busy, o_done, o_err, bus.o_col_ready, bus.o_conv_valid, bus.o_conv_selK_I,
             bus.o_res_valid, bus.o_res_last, o_row, o_col};
        n_checks++;
        if (v !== 30'd0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got %h expected 0", v);
        end
        rst = 1'b0;
        bus.i_col_valid = 1'b0;
        run_frame("w8h8_after_rst", 8, 8, 1'b0, 0, 3, 54, 36, 6);
    endtask

    initial begin
        test_reset();
        run_frame("w5h4", 5, 4, 1'b0, 0, 3, 12, 6, 2);
        run_frame("w3h3", 3, 3, 1'b0, 0, 3, 4, 1, 1);
        test_err("w2", 2, 4);
        test_err("h1025", 5, 1025);
        run_frame("w6h3_toggle", 6, 3, 1'b1, 0, 3, 7, 4, 1);
`ifdef CONV_SEQ_OUT_BP_EN
        run_frame("w5h4_bp", 5, 4, 1'b0, 5, 3, 12, 6, 2);
`endif
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
